xmt_buffer: RTL and testbench

- Transmit-side counterpart of the receive buffer. It takes the 1200 bit/s serial stream leaving the main communications loopback and regroups it LSB-first into 8-bit bytes.
- Bytes are held in a small FIFO and handed one at a time to the RS-232 transmitter holding register.
- Signals completion when a full 10K-bit frame has been received and drained to the UART.

---
 rtl/xmt_pkg.sv | 20 ++
 rtl/xmt_buffer_if.sv | 32 +++
 rtl/xmt_fifo.sv | 62 ++++++
 rtl/xmt_buffer.sv | 191 +++++++++++++++++++
 tb/tb_xmt_buffer.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/xmt_pkg.sv
// Shared definitions for the transmit buffer.
//   - FSM state encodings for the input (bit assembly) and output (UART load) machines
//   - default frame length and frame-counter width
package xmt_pkg;

    localparam int FRAME_BITS_DEFAULT = 10000;
    localparam int FRAME_CNT_W        = 14;

    typedef enum logic {
        IN_IDLE  = 1'b0,
        IN_SHIFT = 1'b1
    } in_state_t;

    typedef enum logic [1:0] {
        OUT_IDLE = 2'd0,
        OUT_LOAD = 2'd1,
        OUT_WAIT = 2'd2
    } out_state_t;

endpackage

// File: rtl/xmt_buffer_if.sv
// UART-side bus of the transmit buffer.
//   tx_ready   : UART transmit holding register empty (UART -> buffer)
//   thr        : byte for the transmit holding register
//   load       : one-cycle strobe, UART latches thr on it
//   tx_full    : FIFO full
//   tx_empty   : FIFO empty
//   overflow   : sticky, a byte was dropped
//   frame_done : one-cycle pulse at end of frame
//
// Handshake: a byte is offered only while tx_ready is high; load is high for
// exactly one cycle with thr valid in that same cycle. After a load the
// buffer offers nothing further until tx_ready has been seen low and then
// high again, so a UART that never drops tx_ready receives a single byte.
interface xmt_buffer_if;
    logic       tx_ready;
    logic [7:0] thr;
    logic       load;
    logic       tx_full;
    logic       tx_empty;
    logic       overflow;
    logic       frame_done;

    modport master (
        input  tx_ready,
        output thr, load, tx_full, tx_empty, overflow, frame_done
    );

    modport slave (
        output tx_ready,
        input  thr, load, tx_full, tx_empty, overflow, frame_done
    );
endinterface

// File: rtl/xmt_fifo.sv
// Synchronous byte FIFO with registered full/empty flags.
//   clk, rst : clock, asynchronous active-high reset
//   push/din : write request and data
//   pop      : read request; dout always shows the oldest entry
//   full     : registered, occupancy == DEPTH after this cycle's push/pop
//   empty    : registered, occupancy == 0 after this cycle's push/pop
//   drop     : combinational, this cycle's push is being discarded
module xmt_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty,
    output logic       drop
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   count;
    logic [AW:0]   count_nxt;
    logic          do_push;
    logic          do_pop;

    // A push into a full FIFO still succeeds when a pop frees a slot in the
    // same cycle.
    always_comb begin
        do_pop    = pop && !empty;
        do_push   = push && (!full || do_pop);
        drop      = push && !do_push;
        count_nxt = count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end

    assign dout = mem[rp];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == (AW+1)'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end

endmodule

// File: rtl/xmt_buffer.sv
// Transmit buffer: regroups the loopback serial stream LSB-first into bytes,
// queues them and hands them one at a time to the UART holding register.
//   xmtbuf_clk : system clock (only clock)
//   reset      : asynchronous active-high reset
//   clk_1200   : loopback bit clock, sampled as data; bit taken on its falling edge
//   databit    : loopback serial data
//   frame_en   : high while the loopback presents frame bits
//   uart       : UART-side bus (see xmt_buffer_if)
//   in_state   : input FSM state (debug)
//   out_state  : output FSM state (debug)
module xmt_buffer
    import xmt_pkg::*;
#(
    parameter int FRAME_BITS = FRAME_BITS_DEFAULT,
    parameter int DEPTH      = 16,
    parameter int AW         = 4
) (
    input  logic         xmtbuf_clk,
    input  logic         reset,
    input  logic         clk_1200,
    input  logic         databit,
    input  logic         frame_en,
    xmt_buffer_if.master uart,
    output in_state_t    in_state,
    output out_state_t   out_state
);

    // ---------------- input synchronisers ----------------
    logic [1:0] clk_sync;
    logic       clk_prev;
    logic [1:0] data_sync;
    logic [1:0] fe_sync;
    logic       samp;
    logic       bit_in;
    logic       fe;

    always_ff @(posedge xmtbuf_clk or posedge reset) begin
        if (reset) begin
            clk_sync  <= '0;
            clk_prev  <= 1'b0;
            data_sync <= '0;
            fe_sync   <= '0;
        end else begin
            clk_sync  <= {clk_sync[0], clk_1200};
            clk_prev  <= clk_sync[1];
            data_sync <= {data_sync[0], databit};
            fe_sync   <= {fe_sync[0], frame_en};
        end
    end

    // One-cycle strobe on the synchronised falling edge of the bit clock.
    assign samp   = clk_prev & ~clk_sync[1];
    assign bit_in = data_sync[1];
    assign fe     = fe_sync[1];

    // ---------------- input FSM ----------------
    in_state_t              in_q;
    in_state_t              in_nxt;
    logic [7:0]             assy;
    logic [2:0]             bit_cnt;
    logic [FRAME_CNT_W-1:0] frame_cnt;
    logic                   push;
    logic                   frame_wrap;
    logic [7:0]             push_byte;

    always_comb begin
        in_nxt     = in_q;
        push       = 1'b0;
        frame_wrap = 1'b0;
        push_byte  = {bit_in, assy[7:1]};
        case (in_q)
            IN_IDLE: begin
                if (fe) in_nxt = IN_SHIFT;
            end
            IN_SHIFT: begin
                if (!fe) begin
                    in_nxt = IN_IDLE;
                end else if (samp) begin
                    push = (bit_cnt == 3'd7);
                    if (frame_cnt == FRAME_CNT_W'(FRAME_BITS - 1)) begin
                        frame_wrap = 1'b1;
                        in_nxt     = IN_IDLE;
                    end
                end
            end
            default: in_nxt = IN_IDLE;
        endcase
    end

    // A partial byte needs no explicit clearing: bit_cnt restarts at 0 and
    // the next eight shifts overwrite every bit of assy.
    always_ff @(posedge xmtbuf_clk or posedge reset) begin
        if (reset) begin
            in_q      <= IN_IDLE;
            assy      <= '0;
            bit_cnt   <= '0;
            frame_cnt <= '0;
        end else begin
            in_q <= in_nxt;
            if (in_q == IN_IDLE || !fe) begin
                bit_cnt <= '0;
            end else if (samp) begin
                assy      <= push_byte;
                bit_cnt   <= bit_cnt + 3'd1;
                frame_cnt <= frame_wrap ? '0 : frame_cnt + 1'b1;
            end
        end
    end

    assign in_state = in_q;

    // ---------------- FIFO ----------------
    logic       pop;
    logic [7:0] fifo_dout;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_drop;

    xmt_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk   (xmtbuf_clk),
        .rst   (reset),
        .push  (push),
        .din   (push_byte),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .drop  (fifo_drop)
    );

    assign uart.tx_full  = fifo_full;
    assign uart.tx_empty = fifo_empty;

    // ---------------- output FSM ----------------
    out_state_t out_q;
    out_state_t out_nxt;
    logic       seen_low;
    logic       eof_arm;

    // The byte is read and popped on the transition into OUT_LOAD so that
    // thr is already stable during the whole cycle load is high.
    always_comb begin
        out_nxt = out_q;
        pop     = 1'b0;
        case (out_q)
            OUT_IDLE: begin
                if (!fifo_empty && uart.tx_ready) begin
                    out_nxt = OUT_LOAD;
                    pop     = 1'b1;
                end
            end
            OUT_LOAD: out_nxt = OUT_WAIT;
            OUT_WAIT: begin
                if (seen_low && uart.tx_ready) out_nxt = OUT_IDLE;
            end
            default: out_nxt = OUT_IDLE;
        endcase
    end

    always_ff @(posedge xmtbuf_clk or posedge reset) begin
        if (reset) begin
            out_q           <= OUT_IDLE;
            seen_low        <= 1'b0;
            eof_arm         <= 1'b0;
            uart.thr        <= '0;
            uart.load       <= 1'b0;
            uart.overflow   <= 1'b0;
            uart.frame_done <= 1'b0;
        end else begin
            out_q           <= out_nxt;
            uart.load       <= pop;
            uart.frame_done <= 1'b0;
            if (pop) uart.thr <= fifo_dout;
            if (fifo_drop) uart.overflow <= 1'b1;

            // tx_ready may already drop in the load cycle, so watch from there.
            if (out_q == OUT_IDLE)    seen_low <= 1'b0;
            else if (!uart.tx_ready)  seen_low <= 1'b1;

            if (frame_wrap) begin
                eof_arm <= 1'b1;
            end else if (eof_arm && fifo_empty && out_q == OUT_IDLE) begin
                eof_arm         <= 1'b0;
                uart.frame_done <= 1'b1;
            end
        end
    end

    assign out_state = out_q;

endmodule

// File: tb/tb_xmt_buffer.sv
module tb_xmt_buffer;
  import xmt_pkg::*;

  localparam int FB    = 80;
  localparam int DEPTH = 16;
  localparam int HALF  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic clk_1200;
  logic databit;
  logic frame_en;
  in_state_t  in_state;
  out_state_t out_state;

  always #5 clk = ~clk;

  xmt_buffer_if bus();

  xmt_buffer #(.FRAME_BITS(FB), .DEPTH(DEPTH), .AW(4)) dut (
    .xmtbuf_clk (clk),
    .reset      (rst),
    .clk_1200   (clk_1200),
    .databit    (databit),
    .frame_en   (frame_en),
    .uart       (bus.master),
    .in_state   (in_state),
    .out_state  (out_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  bit exp_ovf;
  int bit_total;
  int load_cnt;
  int fd_cnt;
  int load_at_fd;
  bit auto_ack;
  bit rand_gap;
  bit ready_cmd;
  int ack_gap;
  int busy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // UART model: in auto mode it drops tx_ready on each load and raises it
  // again after a gap; otherwise tx_ready follows ready_cmd.
  always @(negedge clk) begin
    if (!auto_ack) begin
      busy = 0;
      bus.tx_ready = ready_cmd;
    end else begin
      if (bus.load === 1'b1) busy = rand_gap ? int'($urandom_range(120, 2)) : ack_gap;
      else if (busy > 0) busy--;
      bus.tx_ready = (busy == 0);
    end
  end

  // Load / frame_done monitor against the expected byte queue.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus.load === 1'b1) begin
        check("queue_nonempty_on_load", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          check("thr", bus.thr, mon_exp);
        end
        load_cnt++;
      end
      if (bus.frame_done === 1'b1) begin
        fd_cnt++;
        load_at_fd = load_cnt;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_bit(input logic b);
    databit  = b;
    clk_1200 = 1'b1;
    repeat (HALF) @(posedge clk);
    #1;
    clk_1200 = 1'b0;
    if (frame_en) bit_total++;
    repeat (HALF) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
    if (exp_q.size() < DEPTH) exp_q.push_back(v);
    else exp_ovf = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    exp_ovf    = 1'b0;
    bit_total  = 0;
    load_cnt   = 0;
    fd_cnt     = 0;
    load_at_fd = -1;
    rst = 1'b0;
  endtask

  task automatic start_frame();
    frame_en = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    check({tag, "_drained"}, exp_q.size(), 0);
    repeat (150) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_thr"}, bus.thr, 8'h00);
    check({tag, "_load"}, bus.load, 1'b0);
    check({tag, "_tx_full"}, bus.tx_full, 1'b0);
    check({tag, "_tx_empty"}, bus.tx_empty, 1'b1);
    check({tag, "_overflow"}, bus.overflow, 1'b0);
    check({tag, "_frame_done"}, bus.frame_done, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] v;
    int nb;
    rst = 1'b1; clk_1200 = 1'b1; databit = 1'b0; frame_en = 1'b0;
    auto_ack = 1'b0; rand_gap = 1'b0; ready_cmd = 1'b0; ack_gap = 10;
    exp_ovf = 1'b0; bit_total = 0; load_cnt = 0; fd_cnt = 0; load_at_fd = -1;

    // power-on reset
    do_reset();
    check_reset_values("por");
    check("por_out_state", out_state, OUT_IDLE);

    // 0xA5 and its load latency
    auto_ack = 1'b1; ack_gap = 10;
    start_frame();
    v = 8'hA5;
    for (int i = 0; i < 7; i++) send_bit(v[i]);
    databit = v[7]; clk_1200 = 1'b1;
    repeat (HALF) @(posedge clk);
    #1;
    clk_1200 = 1'b0;
    bit_total++;
    exp_q.push_back(8'hA5);
    repeat (3) @(posedge clk);
    #1;
    check("a5_load_early", bus.load, 1'b0);
    @(posedge clk);
    #1;
    check("a5_load", bus.load, 1'b1);
    check("a5_thr", bus.thr, 8'hA5);
    @(posedge clk);
    #1;
    check("a5_load_one_cycle", bus.load, 1'b0);
    drain("a5");
    check("a5_loads", load_cnt, 1);

    // reset mid-byte, then 0x3C
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    do_reset();
    check_reset_values("midrst");
    send_byte(8'h3C);
    drain("midrst");
    check("midrst_loads", load_cnt, 1);
    check("midrst_thr_held", bus.thr, 8'h3C);

    // partial byte discarded when frame_en drops
    do_reset();
    start_frame();
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    frame_en = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    start_frame();
    send_byte(8'h81);
    drain("partial");
    check("partial_loads", load_cnt, 1);
    check("partial_thr", bus.thr, 8'h81);

    // overflow with tx_ready held low
    do_reset();
    auto_ack = 1'b0; ready_cmd = 1'b0;
    start_frame();
    for (int i = 0; i < 16; i++) send_byte(8'($urandom));
    check("ovf_full", bus.tx_full, exp_q.size() == DEPTH);
    check("ovf_not_yet", bus.overflow, exp_ovf);
    send_byte(8'($urandom));
    check("ovf_set", bus.overflow, exp_ovf);
    check("ovf_still_full", bus.tx_full, 1'b1);
    check("ovf_no_load", load_cnt, 0);
    auto_ack = 1'b1; ack_gap = 6;
    drain("ovf");
    check("ovf_loads", load_cnt, 16);
    check("ovf_empty", bus.tx_empty, 1'b1);
    check("ovf_sticky", bus.overflow, 1'b1);
    check("ovf_frame_done", fd_cnt, bit_total / FB);
    check("ovf_fd_after_drain", load_at_fd, 16);

    // one full frame 0x00..0x09
    do_reset();
    auto_ack = 1'b1; ack_gap = 50;
    start_frame();
    for (int i = 0; i < 10; i++) send_byte(8'(i));
    drain("frame");
    check("frame_loads", load_cnt, 10);
    check("frame_done_count", fd_cnt, 1);
    check("frame_done_after_last", load_at_fd, 10);
    check("frame_no_overflow", bus.overflow, 1'b0);

    // tx_ready stuck high blocks a second load
    do_reset();
    auto_ack = 1'b0; ready_cmd = 1'b1;
    start_frame();
    send_byte(8'($urandom));
    send_byte(8'($urandom));
    repeat (20) @(posedge clk);
    #1;
    check("stuck_one_load", load_cnt, 1);
    ready_cmd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    ready_cmd = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("stuck_second_load", load_cnt, 2);

    // random bytes, random UART gaps
    do_reset();
    auto_ack = 1'b1; rand_gap = 1'b1;
    start_frame();
    nb = int'($urandom_range(12, 4));
    for (int i = 0; i < nb; i++) send_byte(8'($urandom));
    drain("rand");
    check("rand_loads", load_cnt, nb);
    check("rand_overflow", bus.overflow, exp_ovf);
    check("rand_frame_done", fd_cnt, bit_total / FB);
    check("rand_empty", bus.tx_empty, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
